fpu_cmp_arbiter: RTL and testbench

FPU_CMP_ARBITER -- requirements
Module: fpu_cmp_arbiter

---
 rtl/fpu_cmp_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_fpu_cmp_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_cmp_arbiter.sv
// fpu_cmp_arbiter: round-robin arbiter giving N requesters turns on one shared
// half-precision subtract/compare unit over a handshake protocol.
// Latency: 6 cycles from the grant cycle to rsp_valid when the unit answers at once.
// Backpressure: req is level-held; the unit stalls via its acks and result strobe,
// bounded by a watchdog that resets the unit and completes with rsp_err.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req[N]                   level request per requester, held until its rsp_valid bit
//   op_a, op_b [N*16]        packed operands, slice i = [16i+15:16i]
//   rsp_valid[N]             one-hot, one-cycle completion pulse
//   rsp_z, rsp_cmp, rsp_err  result, compare code (00 eq, 01 gt, 10 lt, 11 abort), abort flag
//   busy, gnt_id             not-idle flag, current/last granted index
//   u_a, u_b, u_a_ack, u_b_ack, u_z_stb, u_z, u_z_ack, u_cmp, u_rst   shared unit side
module fpu_cmp_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*16-1:0] op_a,
    input  logic [N*16-1:0] op_b,
    output logic [N-1:0]    rsp_valid,
    output logic [15:0]     rsp_z,
    output logic [1:0]      rsp_cmp,
    output logic            rsp_err,
    output logic            busy,
    output logic [2:0]      gnt_id,
    output logic [15:0]     u_a,
    output logic [15:0]     u_b,
    input  logic            u_a_ack,
    input  logic            u_b_ack,
    input  logic            u_z_stb,
    input  logic [15:0]     u_z,
    output logic            u_z_ack,
    input  logic [1:0]      u_cmp,
    output logic            u_rst
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND_A  = 3'd1,
        S_SEND_B  = 3'd2,
        S_WAIT_Z  = 3'd3,
        S_WAIT_C  = 3'd4,
        S_CAPTURE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [15:0] ABORT_Z   = 16'h7E00;
    localparam logic [1:0]  ABORT_CMP = 2'b11;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_wd;
    logic [2:0]     r_gnt_id;
    logic [2:0]     r_last_gnt;
    logic [15:0]    r_u_a;
    logic [15:0]    r_u_b;
    logic [15:0]    r_rsp_z;
    logic [1:0]     r_rsp_cmp;
    logic           r_rsp_err;

    logic           w_any;
    logic           w_found;
    logic [2:0]     w_pick;
    logic [3:0]     w_base;
    logic [3:0]     w_sum;
    logic [2*N-1:0] w_req2;
    logic [2*N-1:0] w_rot;
    logic [15:0]    w_sel_a;
    logic [15:0]    w_sel_b;
    logic           w_grant;
    logic           w_abort;
    logic           w_z_take;
    logic           w_z_ack;
    logic           w_wd_hit;

    // Round-robin pick: rotate the request vector so bit 0 is the requester
    // after last_gnt, then take the lowest set bit and map back to an index.
    always_comb begin
        w_any   = |req;
        w_found = 1'b0;
        w_pick  = 3'd0;
        w_sum   = 4'd0;
        w_base  = 4'(r_last_gnt) + 4'd1;
        w_req2  = {req, req};
        w_rot   = w_req2 >> w_base;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = 4'(r_last_gnt) + 4'd1 + 4'(k);
                // last_gnt+1+k never exceeds 2N-1, so one subtraction is a full modulo
                w_pick  = (w_sum >= 4'(N)) ? 3'(w_sum - 4'(N)) : 3'(w_sum);
            end
        end
    end

    always_comb begin
        w_sel_a = 16'h0000;
        w_sel_b = 16'h0000;
        for (int i = 0; i < N; i++) begin
            if (w_pick == 3'(i)) begin
                w_sel_a = op_a[i*16 +: 16];
                w_sel_b = op_b[i*16 +: 16];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake controls. A real transfer always wins over a
    // watchdog expiry landing on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_abort     = 1'b0;
        w_z_take    = 1'b0;
        w_z_ack     = 1'b0;
        w_wd_hit    = (r_wd == 8'(TIMEOUT));
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_SEND_A;
                end
            end
            S_SEND_A: begin
                if (u_a_ack) begin
                    w_state_nxt = S_SEND_B;
                end else if (w_wd_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_SEND_B: begin
                if (u_b_ack) begin
                    w_state_nxt = S_WAIT_Z;
                end else if (w_wd_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_WAIT_Z: begin
                w_z_ack = 1'b1;
                if (u_z_stb) begin
                    w_z_take    = 1'b1;
                    w_state_nxt = S_WAIT_C;
                end else if (w_wd_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            // the unit presents its compare code one edge after the result transfer
            S_WAIT_C:  w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Watchdog: restarts on every state change, runs only while waiting on the unit.
    // An expiry always changes state, so the counter never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd <= 8'd0;
        end else if (w_state_nxt != r_state) begin
            r_wd <= 8'd0;
        end else if (r_state == S_SEND_A || r_state == S_SEND_B || r_state == S_WAIT_Z) begin
            r_wd <= r_wd + 8'd1;
        end
    end

    // Grant, operand and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt_id   <= 3'd0;
            r_last_gnt <= 3'(N - 1);
            r_u_a      <= 16'h0000;
            r_u_b      <= 16'h0000;
            r_rsp_z    <= 16'h0000;
            r_rsp_cmp  <= 2'b00;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_gnt_id  <= w_pick;
                r_u_a     <= w_sel_a;
                r_u_b     <= w_sel_b;
                r_rsp_err <= 1'b0;
            end
            if (w_z_take) begin
                r_rsp_z <= u_z;
            end
            if (r_state == S_CAPTURE) begin
                r_rsp_cmp <= u_cmp;
            end
            if (w_abort) begin
                r_rsp_z   <= ABORT_Z;
                r_rsp_cmp <= ABORT_CMP;
                r_rsp_err <= 1'b1;
            end
            if (r_state == S_DONE) begin
                r_last_gnt <= r_gnt_id;
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N; i++) begin
            rsp_valid[i] = (r_state == S_DONE) && (r_gnt_id == 3'(i));
        end
    end

    assign rsp_z   = r_rsp_z;
    assign rsp_cmp = r_rsp_cmp;
    assign rsp_err = r_rsp_err;
    assign busy    = (r_state != S_IDLE);
    assign gnt_id  = r_gnt_id;
    assign u_a     = r_u_a;
    assign u_b     = r_u_b;
    assign u_z_ack = w_z_ack;
    // rsp_err is cleared at every grant, so in DONE it marks exactly the aborted
    // operations: the unit is reset during that single DONE cycle
    assign u_rst   = rst || ((r_state == S_DONE) && r_rsp_err);

endmodule

// File: tb/tb_fpu_cmp_arbiter.sv
module tb_fpu_cmp_arbiter;
    localparam int N = 4;
    localparam int T = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*16-1:0] op_a;
    logic [N*16-1:0] op_b;
    logic [N-1:0]    rsp_valid;
    logic [15:0]     rsp_z;
    logic [1:0]      rsp_cmp;
    logic            rsp_err;
    logic            busy;
    logic [2:0]      gnt_id;
    logic [15:0]     u_a;
    logic [15:0]     u_b;
    logic            u_a_ack;
    logic            u_b_ack;
    logic            u_z_stb;
    logic [15:0]     u_z;
    logic            u_z_ack;
    logic [1:0]      u_cmp;
    logic            u_rst;
    logic [1:0]      cmp_next;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_cmp_arbiter #(.N(N), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_cmp(rsp_cmp), .rsp_err(rsp_err),
        .busy(busy), .gnt_id(gnt_id), .u_a(u_a), .u_b(u_b),
        .u_a_ack(u_a_ack), .u_b_ack(u_b_ack), .u_z_stb(u_z_stb), .u_z(u_z),
        .u_z_ack(u_z_ack), .u_cmp(u_cmp), .u_rst(u_rst)
    );

    // Unit compare-code model: junk (11) while idle, the real code appears one
    // edge after the result transfer.
    always @(posedge clk) begin
        if (u_z_stb && u_z_ack) u_cmp <= cmp_next;
        else if (!busy)         u_cmp <= 2'b11;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction from requester id; inputs change on the falling edge.
    task automatic txn(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] z, input logic [1:0] cmp,
                       input logic [15:0] exp_z, input logic [1:0] exp_cmp,
                       input logic exp_err, input bit drop, input int exp_lat);
        int lat;
        bit got;
        @(negedge clk);
        op_a[id*16 +: 16] = a;
        op_b[id*16 +: 16] = b;
        u_z      = z;
        cmp_next = cmp;
        req[id]  = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 80 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk($sformatf("gnt_id_%0d", id), 32'(gnt_id), 32'(id));
                chk($sformatf("u_a_%0d", id), 32'(u_a), 32'(a));
                chk($sformatf("u_b_%0d", id), 32'(u_b), 32'(b));
                if (drop) req[id] = 1'b0;
            end
            if (rsp_valid != '0) got = 1'b1;
        end
        chk($sformatf("rsp_seen_%0d", id), 32'(got), 32'd1);
        chk($sformatf("rsp_valid_%0d", id), 32'(rsp_valid), 32'(1 << id));
        chk($sformatf("rsp_z_%0d", id), 32'(rsp_z), 32'(exp_z));
        chk($sformatf("rsp_cmp_%0d", id), 32'(rsp_cmp), 32'(exp_cmp));
        chk($sformatf("rsp_err_%0d", id), 32'(rsp_err), 32'(exp_err));
        chk($sformatf("u_rst_done_%0d", id), 32'(u_rst), 32'(exp_err));
        chk($sformatf("latency_%0d", id), 32'(lat), 32'(exp_lat));
        req[id] = 1'b0;
        @(negedge clk);
        chk($sformatf("idle_after_%0d", id), 32'(busy), 32'd0);
        chk($sformatf("no_repulse_%0d", id), 32'(rsp_valid), 32'd0);
        chk($sformatf("u_rst_clear_%0d", id), 32'(u_rst), 32'd0);
    endtask

    initial begin
        int seen;
        int k;
        int bad;
        rst      = 1'b1;
        req      = '0;
        op_a     = '0;
        op_b     = '0;
        u_a_ack  = 1'b1;
        u_b_ack  = 1'b1;
        u_z_stb  = 1'b1;
        u_z      = 16'h0000;
        cmp_next = 2'b00;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_z", 32'(rsp_z), 32'd0);
        chk("rst_rsp_cmp", 32'(rsp_cmp), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_u_a", 32'(u_a), 32'd0);
        chk("rst_u_b", 32'(u_b), 32'd0);
        chk("rst_u_z_ack", 32'(u_z_ack), 32'd0);
        chk("rst_u_rst", 32'(u_rst), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_req", 32'(busy), 32'd0);

        // 1.0-1.0, 2.0-1.0 (req dropped after grant), 1.0-2.0
        txn(0, 16'h3C00, 16'h3C00, 16'h0000, 2'b00, 16'h0000, 2'b00, 1'b0, 1'b0, 6);
        txn(1, 16'h4000, 16'h3C00, 16'h3C00, 2'b01, 16'h3C00, 2'b01, 1'b0, 1'b1, 6);
        txn(2, 16'h3C00, 16'h4000, 16'hBC00, 2'b10, 16'hBC00, 2'b10, 1'b0, 1'b0, 6);

        // Result strobe never arrives: watchdog abort after T cycles in WAIT_Z
        u_z_stb = 1'b0;
        txn(3, 16'h4200, 16'h3C00, 16'h1234, 2'b01, 16'h7E00, 2'b11, 1'b1, 1'b0, 4 + T);
        u_z_stb = 1'b1;

        // Normal completion after an abort clears rsp_err; pointer wrapped 3 -> 0
        txn(0, 16'h4200, 16'h4000, 16'h3C00, 2'b01, 16'h3C00, 2'b01, 1'b0, 1'b0, 6);

        // Reset while in WAIT_Z
        u_z_stb = 1'b0;
        @(negedge clk);
        req[1] = 1'b1;
        repeat (4) @(negedge clk);
        chk("waitz_z_ack", 32'(u_z_ack), 32'd1);
        chk("waitz_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_u_rst", 32'(u_rst), 32'd1);
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_z_ack", 32'(u_z_ack), 32'd0);
        rst    = 1'b0;
        req[1] = 1'b0;
        u_z_stb = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) bad++;
        end
        chk("midrst_no_rsp", 32'(bad), 32'd0);
        chk("midrst_u_rst_off", 32'(u_rst), 32'd0);

        // Rotation with all requests held, starting from a fresh reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        u_z = 16'h5555;
        cmp_next = 2'b00;
        req = '1;
        seen = 0;
        k = 0;
        while (seen < 8 && k < 200) begin
            @(negedge clk);
            k++;
            if (rsp_valid != '0) begin
                chk($sformatf("rr_valid_%0d", seen), 32'(rsp_valid), 32'(1 << (seen % N)));
                chk($sformatf("rr_gnt_%0d", seen), 32'(gnt_id), 32'(seen % N));
                seen++;
                @(negedge clk);
                k++;
                chk($sformatf("rr_gap_%0d", seen), 32'(busy), 32'd0);
            end
        end
        chk("rr_count", 32'(seen), 32'd8);
        req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
